// File: rtl/battleship_turn_ctrl_if.sv
// Battleship controller bundle: player inputs toward the controller,
// game state (cursor, boards, counters, turn flags) back to the consumers.
// master drives buttons/grids (board I/O side); slave is the controller.
interface battleship_turn_ctrl_if #(
    parameter int BOARD_N = 5
);
    localparam int NN = BOARD_N * BOARD_N;
    localparam int CW = $clog2(BOARD_N);
    localparam int LW = $clog2(NN + 1);

    logic            start;
    logic [NN-1:0]   player_grid;
    logic [NN-1:0]   pc_grid;
    logic            right;
    logic            left;
    logic            up;
    logic            down;
    logic            fire;
    logic [CW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic [2*NN-1:0] player_board;
    logic [2*NN-1:0] pc_board;
    logic [LW-1:0]   player_left;
    logic [LW-1:0]   pc_left;
    logic            player_turn;
    logic            pc_turn;
    logic            game_over;
    logic            winner;

    modport master (
        output start, player_grid, pc_grid,
        output right, left, up, down, fire,
        input  cur_row, cur_col, player_board, pc_board,
        input  player_left, pc_left,
        input  player_turn, pc_turn, game_over, winner
    );

    modport slave (
        input  start, player_grid, pc_grid,
        input  right, left, up, down, fire,
        output cur_row, cur_col, player_board, pc_board,
        output player_left, pc_left,
        output player_turn, pc_turn, game_over, winner
    );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// Battleship turn controller: player vs PC turn FSM, cursor, boards,
// hit counters, turn timeout and LFSR-driven PC shooter.
// Ports: clk, rst_n (sync, active low), bus (slave modport of the bundle).
module battleship_turn_ctrl #(
    parameter int          BOARD_N     = 5,
    parameter int          TURN_CYCLES = 50000000,
    parameter int          PC_DELAY    = 25000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                    clk,
    input logic                    rst_n,
    battleship_turn_ctrl_if.slave  bus
);
    localparam int NN = BOARD_N * BOARD_N;
    localparam int CW = $clog2(BOARD_N);
    localparam int LW = $clog2(NN + 1);
    localparam int IW = $clog2(NN);
    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam int DW = $clog2(PC_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_P_TURN, S_P_RESOLVE,
        S_PC_WAIT, S_PC_PICK, S_PC_RESOLVE, S_GAME_OVER
    } state_t;

    state_t          state_q, state_d;
    logic            start_q;
    logic [4:0]      btn_q;
    logic [NN-1:0]   pgrid_q, pgrid_d, cgrid_q, cgrid_d;
    logic [2*NN-1:0] pboard_q, pboard_d, cboard_q, cboard_d;
    logic [LW-1:0]   pleft_q, pleft_d, cleft_q, cleft_d;
    logic [CW-1:0]   row_q, row_d, col_q, col_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   wait_q, wait_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            first_q, first_d;
    logic            winner_q, winner_d;

    logic [4:0]      btn_now, btn_edge;
    logic            start_edge;
    logic [IW-1:0]   cur_idx, lfsr_mod, cand;
    logic [LW-1:0]   pcount, ccount;
    logic            fire_ok;

    function automatic logic [LW-1:0] popcnt(input logic [NN-1:0] v);
        logic [LW-1:0] s;
        s = '0;
        for (int i = 0; i < NN; i++) s = s + LW'(v[i]);
        return s;
    endfunction

    // {right, left, up, down, fire}
    assign btn_now    = {bus.right, bus.left, bus.up, bus.down, bus.fire};
    assign btn_edge   = btn_now & ~btn_q;
    assign start_edge = bus.start & ~start_q;
    assign cur_idx    = IW'(row_q) * IW'(BOARD_N) + IW'(col_q);
    assign lfsr_mod   = IW'(lfsr_q % 16'(NN));
    assign cand       = first_q ? lfsr_mod : idx_q;
    assign pcount     = popcnt(pgrid_q);
    assign ccount     = popcnt(cgrid_q);
    assign fire_ok    = btn_edge[0] && (cboard_q[2*cur_idx +: 2] == 2'b00);

    always_comb begin
        state_d  = state_q;
        pgrid_d  = pgrid_q;
        cgrid_d  = cgrid_q;
        pboard_d = pboard_q;
        cboard_d = cboard_q;
        pleft_d  = pleft_q;
        cleft_d  = cleft_q;
        row_d    = row_q;
        col_d    = col_q;
        timer_d  = timer_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        first_d  = first_q;
        winner_d = winner_q;
        // taps 16,14,13,11; frozen only while idle
        lfsr_d   = (state_q == S_IDLE) ? lfsr_q
                 : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d = S_LOAD;
                    pgrid_d = bus.player_grid;
                    cgrid_d = bus.pc_grid;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < NN; i++)
                    pboard_d[2*i +: 2] = {1'b0, pgrid_q[i]};
                cboard_d = '0;
                pleft_d  = pcount;
                cleft_d  = ccount;
                row_d    = '0;
                col_d    = '0;
                timer_d  = '0;
                wait_d   = '0;
                lfsr_d   = LFSR_SEED;
                winner_d = (pcount == '0);
                state_d  = (pcount == '0 || ccount == '0) ? S_GAME_OVER : S_P_TURN;
            end
            S_P_TURN: begin
                if (fire_ok) begin
                    // the shot uses the cursor as it was before any move this cycle
                    state_d = S_P_RESOLVE;
                    idx_d   = cur_idx;
                    timer_d = '0;
                end else begin
                    if (timer_q == TW'(TURN_CYCLES - 1)) begin
                        state_d = S_PC_WAIT;
                        timer_d = '0;
                        wait_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                    if (btn_edge[4]) begin
                        if (col_q != CW'(BOARD_N - 1)) col_d = col_q + CW'(1);
                    end else if (btn_edge[3]) begin
                        if (col_q != '0) col_d = col_q - CW'(1);
                    end else if (btn_edge[2]) begin
                        if (row_q != '0) row_d = row_q - CW'(1);
                    end else if (btn_edge[1]) begin
                        if (row_q != CW'(BOARD_N - 1)) row_d = row_q + CW'(1);
                    end
                end
            end
            S_P_RESOLVE: begin
                state_d = S_PC_WAIT;
                wait_d  = '0;
                if (cgrid_q[idx_q]) begin
                    cboard_d[2*idx_q +: 2] = 2'b11;
                    if (cleft_q != '0) cleft_d = cleft_q - LW'(1);
                    if (cleft_q <= LW'(1)) begin
                        state_d  = S_GAME_OVER;
                        winner_d = 1'b0;
                    end
                end else begin
                    cboard_d[2*idx_q +: 2] = 2'b10;
                end
            end
            S_PC_WAIT: begin
                if (wait_q == DW'(PC_DELAY - 1)) begin
                    state_d = S_PC_PICK;
                    wait_d  = '0;
                    first_d = 1'b1;
                end else begin
                    wait_d = wait_q + DW'(1);
                end
            end
            S_PC_PICK: begin
                // linear probe past cells that were already shot
                first_d = 1'b0;
                if (!pboard_q[2*cand+1]) begin
                    idx_d   = cand;
                    state_d = S_PC_RESOLVE;
                end else begin
                    idx_d = (cand == IW'(NN - 1)) ? '0 : cand + IW'(1);
                end
            end
            S_PC_RESOLVE: begin
                state_d = S_P_TURN;
                timer_d = '0;
                if (pboard_q[2*idx_q]) begin
                    pboard_d[2*idx_q +: 2] = 2'b11;
                    if (pleft_q != '0) pleft_d = pleft_q - LW'(1);
                    if (pleft_q <= LW'(1)) begin
                        state_d  = S_GAME_OVER;
                        winner_d = 1'b1;
                    end
                end else begin
                    pboard_d[2*idx_q +: 2] = 2'b10;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            btn_q    <= '0;
            pgrid_q  <= '0;
            cgrid_q  <= '0;
            pboard_q <= '0;
            cboard_q <= '0;
            pleft_q  <= '0;
            cleft_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            timer_q  <= '0;
            wait_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            idx_q    <= '0;
            first_q  <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            btn_q    <= btn_now;
            pgrid_q  <= pgrid_d;
            cgrid_q  <= cgrid_d;
            pboard_q <= pboard_d;
            cboard_q <= cboard_d;
            pleft_q  <= pleft_d;
            cleft_q  <= cleft_d;
            row_q    <= row_d;
            col_q    <= col_d;
            timer_q  <= timer_d;
            wait_q   <= wait_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            winner_q <= winner_d;
        end
    end

    assign bus.cur_row      = row_q;
    assign bus.cur_col      = col_q;
    assign bus.player_board = pboard_q;
    assign bus.pc_board     = cboard_q;
    assign bus.player_left  = pleft_q;
    assign bus.pc_left      = cleft_q;
    assign bus.player_turn  = (state_q == S_P_TURN);
    assign bus.pc_turn      = (state_q == S_PC_WAIT) || (state_q == S_PC_PICK)
                           || (state_q == S_PC_RESOLVE);
    assign bus.game_over    = (state_q == S_GAME_OVER);
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed testbench for battleship_turn_ctrl (5x5 board, short timers).
// Drives and samples on the falling clock edge.
module tb_battleship_turn_ctrl;
    localparam int N  = 5;
    localparam int NN = 25;
    localparam int TC = 64;
    localparam int PD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int hits = 0;

    always #5 clk = ~clk;

    battleship_turn_ctrl_if #(.BOARD_N(N)) bus ();

    battleship_turn_ctrl #(
        .BOARD_N(N), .TURN_CYCLES(TC), .PC_DELAY(PD), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no finish want finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0 right, 1 left, 2 up, 3 down, 4 fire
    task automatic press(input int b);
        case (b)
            0: bus.right = 1'b1;
            1: bus.left = 1'b1;
            2: bus.up = 1'b1;
            3: bus.down = 1'b1;
            default: bus.fire = 1'b1;
        endcase
        cyc(1);
        {bus.right, bus.left, bus.up, bus.down, bus.fire} = '0;
        cyc(1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
    endtask

    function automatic int cnt(input logic [49:0] b, input logic [1:0] v);
        int c = 0;
        for (int i = 0; i < NN; i++) if (b[2*i +: 2] == v) c++;
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.player_turn, bus.pc_turn, bus.game_over, bus.winner} !== 4'b0) begin
            $display("FAIL %s flags: got %b want 0000", tag,
                     {bus.player_turn, bus.pc_turn, bus.game_over, bus.winner});
            errors++;
        end
        checks++;
        if ({bus.cur_row, bus.cur_col} !== 6'd0) begin
            $display("FAIL %s cursor: got %0d,%0d want 0,0", tag, bus.cur_row, bus.cur_col);
            errors++;
        end
        checks++;
        if ({bus.player_board, bus.pc_board} !== 100'd0) begin
            $display("FAIL %s boards: got %h/%h want 0", tag, bus.player_board, bus.pc_board);
            errors++;
        end
        checks++;
        if ({bus.player_left, bus.pc_left} !== 10'd0) begin
            $display("FAIL %s counters: got %0d/%0d want 0/0", tag, bus.player_left, bus.pc_left);
            errors++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.player_grid = '0;
        bus.pc_grid = '0;
        {bus.right, bus.left, bus.up, bus.down, bus.fire} = '0;
        rst_n = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_start();
        bus.player_grid = 25'h1;
        bus.pc_grid = 25'h1;
        pulse_start();
        checks++;
        if (bus.player_left !== 3'd1 || bus.pc_left !== 3'd1) begin
            $display("FAIL start_counts: got %0d/%0d want 1/1", bus.player_left, bus.pc_left);
            errors++;
        end
        checks++;
        if (bus.player_turn !== 1'b1) begin
            $display("FAIL start_turn: got %b want 1", bus.player_turn);
            errors++;
        end
        checks++;
        if (bus.player_board !== 50'h1 || bus.pc_board !== 50'h0) begin
            $display("FAIL start_boards: got %h/%h want 1/0", bus.player_board, bus.pc_board);
            errors++;
        end
    endtask

    task automatic test_cursor();
        bus.right = 1'b1;
        bus.left = 1'b1;
        cyc(1);
        {bus.right, bus.left} = '0;
        cyc(1);
        checks++;
        if (bus.cur_row !== 3'd0 || bus.cur_col !== 3'd1) begin
            $display("FAIL cursor_prio: got %0d,%0d want 0,1", bus.cur_row, bus.cur_col);
            errors++;
        end
        press(1);
        checks++;
        if (bus.cur_col !== 3'd0) begin
            $display("FAIL cursor_left: got %0d want 0", bus.cur_col);
            errors++;
        end
        repeat (6) press(0);
        repeat (6) press(3);
        checks++;
        if (bus.cur_row !== 3'd4 || bus.cur_col !== 3'd4) begin
            $display("FAIL cursor_sat_hi: got %0d,%0d want 4,4", bus.cur_row, bus.cur_col);
            errors++;
        end
        repeat (5) press(2);
        repeat (5) press(1);
        checks++;
        if (bus.cur_row !== 3'd0 || bus.cur_col !== 3'd0) begin
            $display("FAIL cursor_sat_lo: got %0d,%0d want 0,0", bus.cur_row, bus.cur_col);
            errors++;
        end
    endtask

    task automatic test_win_fire();
        press(4);
        checks++;
        if (bus.pc_board !== 50'h3 || bus.pc_left !== 3'd0) begin
            $display("FAIL win_board: got %h/%0d want 3/0", bus.pc_board, bus.pc_left);
            errors++;
        end
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.player_turn !== 1'b0) begin
            $display("FAIL win_flags: got go=%b w=%b pt=%b want 1 0 0",
                     bus.game_over, bus.winner, bus.player_turn);
            errors++;
        end
        press(0);
        press(4);
        checks++;
        if (bus.pc_board !== 50'h3 || bus.cur_col !== 3'd0 || bus.game_over !== 1'b1) begin
            $display("FAIL win_hold: got %h col=%0d go=%b want 3 0 1",
                     bus.pc_board, bus.cur_col, bus.game_over);
            errors++;
        end
    endtask

    task automatic wait_flag(input bit pc, input int bound, output int n);
        n = 0;
        while ((pc ? bus.pc_turn : bus.player_turn) !== 1'b1 && n < bound) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= bound) begin
            $display("FAIL wait_%s: got timeout after %0d want flag", pc ? "pc" : "player", n);
            errors++;
        end
    endtask

    task automatic test_miss_and_pc();
        logic [49:0] expb;
        int n;
        bus.player_grid = 25'h1FFFFFF;
        bus.pc_grid = 25'h1;
        pulse_start();
        checks++;
        if (bus.player_left !== 5'd25 || bus.pc_left !== 3'd1 || bus.player_turn !== 1'b1) begin
            $display("FAIL restart: got %0d/%0d pt=%b want 25/1 1",
                     bus.player_left, bus.pc_left, bus.player_turn);
            errors++;
        end
        pulse_start();
        checks++;
        if (bus.player_turn !== 1'b1 || bus.player_left !== 5'd25) begin
            $display("FAIL start_ignored: got pt=%b pl=%0d want 1 25", bus.player_turn, bus.player_left);
            errors++;
        end
        repeat (2) press(3);
        repeat (3) press(0);
        press(4);
        expb = '0;
        expb[27:26] = 2'b10;
        checks++;
        if (bus.pc_board !== expb || bus.pc_turn !== 1'b1 || bus.player_turn !== 1'b0) begin
            $display("FAIL miss: got %h pc=%b pt=%b want %h 1 0",
                     bus.pc_board, bus.pc_turn, bus.player_turn, expb);
            errors++;
        end
        wait_flag(1'b0, 100, n);
        checks++;
        if (n !== PD + 2) begin
            $display("FAIL pc_latency: got %0d want %0d", n, PD + 2);
            errors++;
        end
        hits = 1;
        checks++;
        if (bus.player_left !== 5'(25 - hits) || cnt(bus.player_board, 2'b11) !== hits) begin
            $display("FAIL pc_shot1: got pl=%0d hits=%0d want %0d %0d",
                     bus.player_left, cnt(bus.player_board, 2'b11), 25 - hits, hits);
            errors++;
        end
        press(4);
        checks++;
        if (bus.player_turn !== 1'b1 || bus.pc_board !== expb) begin
            $display("FAIL refire: got pt=%b %h want 1 %h", bus.player_turn, bus.pc_board, expb);
            errors++;
        end
    endtask

    task automatic test_timeout();
        logic [49:0] pcb;
        int n;
        wait_flag(1'b1, TC + 10, n);
        wait_flag(1'b0, 20, n);
        hits++;
        pcb = bus.pc_board;
        n = 0;
        while (bus.player_turn === 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n !== TC || bus.pc_turn !== 1'b1) begin
            $display("FAIL timeout: got %0d cycles pc=%b want %0d 1", n, bus.pc_turn, TC);
            errors++;
        end
        checks++;
        if (bus.pc_board !== pcb) begin
            $display("FAIL timeout_board: got %h want %h", bus.pc_board, pcb);
            errors++;
        end
        for (int r = 0; r < 5; r++) begin
            wait_flag(1'b0, 20, n);
            hits++;
            checks++;
            if (cnt(bus.player_board, 2'b11) !== hits || cnt(bus.player_board, 2'b10) !== 0
                || bus.player_left !== 5'(25 - hits)) begin
                $display("FAIL pc_fresh_cell: got hits=%0d pl=%0d want %0d %0d",
                         cnt(bus.player_board, 2'b11), bus.player_left, hits, 25 - hits);
                errors++;
            end
            wait_flag(1'b1, TC + 10, n);
        end
    endtask

    task automatic test_no_ships();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.player_grid = '0;
        bus.pc_grid = 25'h1;
        cyc(1);
        pulse_start();
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b1 || bus.player_turn !== 1'b0) begin
            $display("FAIL no_ships: got go=%b w=%b pt=%b want 1 1 0",
                     bus.game_over, bus.winner, bus.player_turn);
            errors++;
        end
        checks++;
        if (bus.player_left !== 5'd0 || bus.pc_left !== 5'd1) begin
            $display("FAIL no_ships_cnt: got %0d/%0d want 0/1", bus.player_left, bus.pc_left);
            errors++;
        end
    endtask

    task automatic test_reset_pick();
        bus.player_grid = 25'h1FFFFFF;
        bus.pc_grid = 25'h1;
        pulse_start();
        press(0);
        press(4);
        cyc(PD);
        checks++;
        if (bus.pc_turn !== 1'b1 || bus.pc_board[3:2] !== 2'b10) begin
            $display("FAIL pre_pick: got pc=%b cell1=%b want 1 10", bus.pc_turn, bus.pc_board[3:2]);
            errors++;
        end
        rst_n = 1'b0;
        cyc(1);
        check_all_zero("reset_pick");
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_start();
        test_cursor();
        test_win_fire();
        test_miss_and_pc();
        test_timeout();
        test_no_ships();
        test_reset_pick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
